vga_pixel_ctrl: RTL
===================

# vga_pixel_ctrl

Raster timing and pixel output stage for the 640x480 card-game display. The block generates the `HCount`/`VCount` raster coordinates that every card renderer consumes, and collects the renderers' `cardon`/`rgb` replies back into the screen stream. It blanks everything outside the visible area and drives registered `hsync`, `vsync` and 3-bit `rgb` to the VGA connector. One pixel-pipeline stage keeps sync and colour aligned.

## Interface
Parameters:
- `DIV`, 2: system clocks per pixel (50 MHz clk to a 25 MHz pixel rate).
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `HCount` out 10: current pixel column, 0..H_TOTAL-1 (H_TOTAL = 800).
- `VCount` out 10: current line, 0..V_TOTAL-1 (V_TOTAL = 525).
- `video_on` out 1: combinational; `HCount < H_DISPLAY && VCount < V_DISPLAY`.
- `p_tick` out 1: one-clk pixel-enable strobe.
- `frame_start` out 1: one-clk pulse at the start of each frame.
- `cardon` in 1: OR of all card renderers' `cardon` outputs.
- `card_rgb` in 3: colour from the active card renderer.
- `bg_rgb` in 3: background/table colour.
- `hsync` out 1: registered, active low.
- `vsync` out 1: registered, active low.
- `rgb` out 3: registered pixel colour.

## Operation
- Divider: `div_cnt` counts 0..DIV-1 on every clk. `p_tick` is high for exactly the one clk in which `div_cnt == DIV-1`.
- Horizontal counter: on `p_tick`, `HCount` increments. At H_TOTAL-1 it wraps to 0 and `VCount` advances.
- Vertical counter: at V_TOTAL-1, `VCount` wraps to 0 on the same tick that `HCount` wraps.
- Counters change only on `p_tick`; they hold between ticks.
- Raw horizontal sync is active for `HCount` in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1], i.e. [656, 751].
- Raw vertical sync is active for `VCount` in [490, 491].
- Pixel mux, evaluated on the current counts:
  - `!video_on` gives 000.
  - else `cardon` gives `card_rgb`.
  - else `bg_rgb`.
- `cardon` has priority over the background. `card_rgb` is ignored whenever `cardon` is 0.
- Output stage: on `p_tick`, the mux result, the inverted raw hsync and the inverted raw vsync are registered into `rgb`, `hsync` and `vsync`. The three outputs always change together.
- `frame_start`: registered. It is high for exactly one clk, the clk following the `p_tick` that loads (HCount, VCount) = (0, 0).
- Reset values, all asynchronous:
  - `div_cnt`, `HCount`, `VCount`: 0.
  - `hsync`, `vsync`: 1 (inactive).
  - `rgb`: 000.
  - `frame_start`: 0.
- `p_tick` is low while `reset` is high.
- Reset mid-frame: all state returns to the reset values immediately. The first `p_tick` after release occurs DIV clks later and advances `HCount` to 1.

## Timing
- Pixel period: DIV clks. Line period: 800 × DIV = 1600 clks. Frame period: 525 lines = 840 000 clks.
- Latency: `rgb`/`hsync`/`vsync` reflect the counts of the previous pixel. The raster sampled at tick n appears on the outputs after tick n, stable for DIV clks.
- Card renderers are combinational on `HCount`/`VCount`. `cardon`/`card_rgb` must settle within one pixel period, before the next `p_tick`.
- `hsync` low width: 96 pixels = 192 clks, once per line.
- `vsync` low width: 2 lines = 3200 clks, once per frame.
- No state transitions other than counter wrap. Simultaneous H and V wrap produces exactly one `frame_start`.

## Test plan
- Reset and release, DIV=2:
  - All outputs are at their reset values during reset.
  - First `p_tick` arrives 2 clks after release.
  - `HCount` reaches 799 after 1598 clks, then wraps to 0 while `VCount` becomes 1.
- Horizontal sync, one full line:
  - `hsync` goes low on the output tick after `HCount` = 656 is sampled.
  - It stays low for exactly 192 clks.
  - Line period is 1600 clks.
- Vertical sync and frame, 2 frames:
  - `vsync` is low for 3200 clks per frame.
  - `frame_start` pulses exactly twice, 840 000 clks apart.
  - Each pulse is 1 clk wide.
- Pixel mux:
  - `bg_rgb`=001 and `cardon`=1 with `card_rgb`=100 inside the box (130..219, 70..159).
  - `rgb` = 100 inside the box and 001 elsewhere in the visible area.
  - `rgb` = 000 at `HCount` ≥ 640 or `VCount` ≥ 480, even with `cardon` forced to 1.
- Reset asserted mid-line at `HCount`=300, `VCount`=200:
  - Counters and outputs clear within the same clk, asynchronously.
  - The normal sequence restarts from (0, 0) after release.

Source files
------------

// File: rtl/vga_pixel_ctrl.sv
// Raster counters plus registered sync/colour output stage for a 640x480 VGA display; no backpressure.
// rgb/hsync/vsync show the previous pixel's counts; frame_start follows the tick that loads (0,0).
module vga_pixel_ctrl #(
   parameter int DIV       = 2,
   parameter int H_DISPLAY = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] HCount,
   output logic [9:0] VCount,
   output logic       video_on,
   output logic       p_tick,
   output logic       frame_start,
   input  logic       cardon,
   input  logic [2:0] card_rgb,
   input  logic [2:0] bg_rgb,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb
);
   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0]    V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0]    HS_FIRST = 10'(H_DISPLAY + H_FP);
   localparam logic [9:0]    HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam logic [9:0]    VS_FIRST = 10'(V_DISPLAY + V_FP);
   localparam logic [9:0]    VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]    h_cnt_q, h_cnt_d;
   logic [9:0]    v_cnt_q, v_cnt_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic [2:0]    rgb_q, rgb_d;
   logic          frame_start_q, frame_start_d;

   logic          h_wrap, v_wrap, hs_raw, vs_raw;
   logic [2:0]    pix;

   // Gated with reset so DIV=1 (divider stuck at its last value) cannot tick in reset.
   assign p_tick   = (div_cnt_q == DIV_LAST) && !reset;
   assign video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
   assign h_wrap   = (h_cnt_q == H_LAST);
   assign v_wrap   = (v_cnt_q == V_LAST);
   assign hs_raw   = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
   assign vs_raw   = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);

   always_comb begin
      pix = 3'b000;
      if (video_on) begin
         pix = cardon ? card_rgb : bg_rgb;
      end
   end

   always_comb begin
      div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      if (p_tick) begin
         h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
         end
         // Sync and colour are captured from the same counts so they stay aligned.
         rgb_d         = pix;
         hsync_d       = !hs_raw;
         vsync_d       = !vs_raw;
         frame_start_d = h_wrap && v_wrap;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q     <= '0;
         h_cnt_q       <= 10'd0;
         v_cnt_q       <= 10'd0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= 3'b000;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign HCount      = h_cnt_q;
   assign VCount      = v_cnt_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;
   assign frame_start = frame_start_q;

endmodule
